// File: rtl/filtro_load_pkg.sv
// Shared definitions for the registered load filter: size codes, the
// pipeline state encoding and the alignment rule used on every accept.
package filtro_load_pkg;

    // Size codes carried on i_size
    localparam logic [1:0] SZ_FULL = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // WAIT_NEXT is only reachable when the unaligned merge path is built
    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        FULL      = 2'b01,
        WAIT_NEXT = 2'b10
    } state_e;

    // Natural alignment check; byte loads can never be misaligned.
    // The offset is passed zero-extended so one function serves any width.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [7:0] offset);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset[1:0] != 2'b00);
            SZ_FULL: mis = (offset != 8'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/filtro_load_pipe_extender.sv
// load_extender: shifts the addressed lane down to bit 0, selects the
// byte/halfword/word/full field and sign- or zero-extends it to NBITS.
// The input is two words wide so the same block serves the direct path
// (upper word zero) and the merge of two sequential words.
module load_extender
    import filtro_load_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int BYTENBITS = 8,
    parameter int TNBITS    = 2,
    parameter int OFFBITS   = 2
)(
    input  logic [2*NBITS-1:0] word_i,
    input  logic [OFFBITS-1:0] offset_i,
    input  logic [TNBITS-1:0]  size_i,
    input  logic               cero_i,
    output logic [NBITS-1:0]   dato_o
);

    localparam int SHW      = OFFBITS + $clog2(BYTENBITS);
    localparam int WORDBITS = (NBITS > 4*BYTENBITS) ? 4*BYTENBITS : NBITS;

    logic [SHW-1:0]   shamt;
    logic [NBITS-1:0] lane;
    logic             fillBit;
    int               fieldBits;

    assign shamt = SHW'(offset_i) * SHW'(BYTENBITS);
    assign lane  = NBITS'(word_i >> shamt);

    // Pick the field width and its top bit, then fill everything above it
    always_comb begin
        fieldBits = NBITS;
        fillBit   = lane[NBITS-1];
        case (size_i)
            SZ_BYTE: begin
                fieldBits = BYTENBITS;
                fillBit   = lane[BYTENBITS-1];
            end
            SZ_HALF: begin
                fieldBits = 2*BYTENBITS;
                fillBit   = lane[2*BYTENBITS-1];
            end
            SZ_WORD: begin
                fieldBits = WORDBITS;
                fillBit   = lane[WORDBITS-1];
            end
            default: begin
                fieldBits = NBITS;
                fillBit   = lane[NBITS-1];
            end
        endcase
        fillBit = fillBit & ~cero_i;
        dato_o  = lane;
        for (int i = 0; i < NBITS; i++) begin
            if (i >= fieldBits) dato_o[i] = fillBit;
        end
    end

endmodule

// File: rtl/filtro_load_pipe.sv
// filtro_load_pipe: MEM-stage load filter behind a single-entry valid/ready
// register. Aligns and extends the addressed field, flags misaligned and
// illegal-size accesses. Optional macro FILTRO_LOAD_UNALIGNED_EN replaces
// the misaligned error with a fetch of the next word and a merged result.
module filtro_load_pipe
    import filtro_load_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int BYTENBITS = 8,
    parameter int TNBITS    = 2,
    parameter int OFFBITS   = 2
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NBITS-1:0]   i_data,
    input  logic [OFFBITS-1:0] i_offset,
    input  logic [TNBITS-1:0]  i_size,
    input  logic               i_cero,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NBITS-1:0]   o_dato,
    output logic               o_error,
    output logic               o_req_next,
    input  logic [NBITS-1:0]   i_next_data,
    input  logic               i_next_valid
);

    // A 32-bit word load only exists on the 64-bit datapath
    localparam bit WORD_ILLEGAL = (NBITS == 32);

    state_e           state_q;
    logic             valid_q;
    logic             error_q;
    logic [NBITS-1:0] dato_q;

    logic             accept;
    logic             illegalSize;
    logic             misaligned;
    logic             deferLoad;
    logic [NBITS-1:0] directDato;
    logic [NBITS-1:0] loadDato;
    logic             loadError;

    load_extender #(
        .NBITS(NBITS), .BYTENBITS(BYTENBITS), .TNBITS(TNBITS), .OFFBITS(OFFBITS)
    ) uDirect (
        .word_i   ({{NBITS{1'b0}}, i_data}),
        .offset_i (i_offset),
        .size_i   (i_size),
        .cero_i   (i_cero),
        .dato_o   (directDato)
    );

    assign accept      = i_valid & o_ready;
    assign illegalSize = WORD_ILLEGAL && (i_size == SZ_WORD);
    assign misaligned  = isMisaligned(2'(i_size), 8'(i_offset));

`ifdef FILTRO_LOAD_UNALIGNED_EN
    logic [NBITS-1:0]   savedData_q;
    logic [OFFBITS-1:0] savedOffset_q;
    logic [TNBITS-1:0]  savedSize_q;
    logic               savedCero_q;
    logic               reqNext_q;
    logic [NBITS-1:0]   mergeDato;

    load_extender #(
        .NBITS(NBITS), .BYTENBITS(BYTENBITS), .TNBITS(TNBITS), .OFFBITS(OFFBITS)
    ) uMerge (
        .word_i   ({i_next_data, savedData_q}),
        .offset_i (savedOffset_q),
        .size_i   (savedSize_q),
        .cero_i   (savedCero_q),
        .dato_o   (mergeDato)
    );

    assign o_req_next = reqNext_q;
`else
    logic unusedNext;
    assign unusedNext = ^{i_next_data, i_next_valid};
    assign o_req_next = 1'b0;
`endif

    // What an accept this cycle would register; illegal size wins over alignment
    always_comb begin
        loadDato  = directDato;
        loadError = 1'b0;
        deferLoad = 1'b0;
        if (illegalSize) begin
            loadDato  = '1;
            loadError = 1'b1;
        end else if (misaligned) begin
`ifdef FILTRO_LOAD_UNALIGNED_EN
            deferLoad = 1'b1;
`else
            loadDato  = '0;
            loadError = 1'b1;
`endif
        end
    end

    // Ready follows downstream while full so drain and reload share a cycle
    always_comb begin
        case (state_q)
            EMPTY:   o_ready = 1'b1;
            FULL:    o_ready = i_ready;
            default: o_ready = 1'b0;
        endcase
    end

    // Pipeline register FSM with registered valid/data/error/request outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            dato_q  <= '0;
            error_q <= 1'b0;
`ifdef FILTRO_LOAD_UNALIGNED_EN
            reqNext_q     <= 1'b0;
            savedData_q   <= '0;
            savedOffset_q <= '0;
            savedSize_q   <= '0;
            savedCero_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                EMPTY, FULL: begin
                    if (accept) begin
                        state_q <= FULL;
                        valid_q <= 1'b1;
                        dato_q  <= loadDato;
                        error_q <= loadError;
`ifdef FILTRO_LOAD_UNALIGNED_EN
                        if (deferLoad) begin
                            state_q       <= WAIT_NEXT;
                            valid_q       <= 1'b0;
                            reqNext_q     <= 1'b1;
                            savedData_q   <= i_data;
                            savedOffset_q <= i_offset;
                            savedSize_q   <= i_size;
                            savedCero_q   <= i_cero;
                        end
`endif
                    end else if ((state_q == FULL) && i_ready) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
`ifdef FILTRO_LOAD_UNALIGNED_EN
                WAIT_NEXT: begin
                    if (i_next_valid) begin
                        state_q   <= FULL;
                        valid_q   <= 1'b1;
                        dato_q    <= mergeDato;
                        error_q   <= 1'b0;
                        reqNext_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_dato  = dato_q;
    assign o_error = error_q;

endmodule

// File: tb/tb_filtro_load_pipe.sv
// Bench for filtro_load_pipe: a 32-bit and a 64-bit instance share one
// stimulus stream; a behavioural model checks both every cycle and
// directed literals pin the key cases. Honours FILTRO_LOAD_UNALIGNED_EN.
module tb_filtro_load_pipe;

`ifdef FILTRO_LOAD_UNALIGNED_EN
    localparam bit UNAL = 1'b1;
`else
    localparam bit UNAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, valid, readyIn, cero, nextValid;
    logic [63:0] data, nextData;
    logic [2:0]  offset;
    logic [1:0]  size;

    logic        ready32, valid32, err32, req32;
    logic [31:0] dato32;
    logic        ready64, valid64, err64, req64;
    logic [63:0] dato64;

    int total = 0;
    int bad   = 0;
    bit modelOn = 1'b0;

    // Model state per instance: 0 = 32-bit, 1 = 64-bit
    bit          mHave[2];
    bit          mWait[2];
    bit          mErr[2];
    logic [63:0] mDato[2];
    logic [63:0] sWord[2];
    int          sOff[2];
    int          sSize[2];
    bit          sCero[2];

    typedef struct {
        logic [63:0] d;
        logic [2:0]  off;
        logic [1:0]  sz;
        bit          c;
    } vec_t;

    vec_t vecs[7] = '{
        '{64'hF1E2_D3C4_B5A6_9788, 3'd7, 2'b01, 1'b0},
        '{64'hF1E2_D3C4_B5A6_9788, 3'd6, 2'b10, 1'b1},
        '{64'hF1E2_D3C4_B5A6_9788, 3'd4, 2'b11, 1'b1},
        '{64'hF1E2_D3C4_B5A6_9788, 3'd2, 2'b11, 1'b0},
        '{64'hF1E2_D3C4_B5A6_9788, 3'd0, 2'b00, 1'b0},
        '{64'hF1E2_D3C4_B5A6_9788, 3'd5, 2'b00, 1'b1},
        '{64'hF1E2_D3C4_B5A6_9788, 3'd3, 2'b01, 1'b1}
    };

    always #5 clk = ~clk;

    filtro_load_pipe #(.NBITS(32), .BYTENBITS(8), .TNBITS(2), .OFFBITS(2)) dut32 (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .o_ready(ready32),
        .i_data(data[31:0]), .i_offset(offset[1:0]), .i_size(size), .i_cero(cero),
        .o_valid(valid32), .i_ready(readyIn), .o_dato(dato32), .o_error(err32),
        .o_req_next(req32), .i_next_data(nextData[31:0]), .i_next_valid(nextValid)
    );

    filtro_load_pipe #(.NBITS(64), .BYTENBITS(8), .TNBITS(2), .OFFBITS(3)) dut64 (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .o_ready(ready64),
        .i_data(data), .i_offset(offset), .i_size(size), .i_cero(cero),
        .o_valid(valid64), .i_ready(readyIn), .o_dato(dato64), .o_error(err64),
        .o_req_next(req64), .i_next_data(nextData), .i_next_valid(nextValid)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] maskN(input int n);
        return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    endfunction

    // Load semantics straight from the rules: shift, take field, extend
    task automatic refLoad(input int nb, input logic [127:0] word, input int off, input int sz,
                           input bit c, input bit merged,
                           output logic [63:0] d, output bit e, output bit defer);
        int           fw;
        bit           mis;
        bit           illegal;
        logic [127:0] lane;
        lane    = word >> (8*off);
        illegal = (sz == 3) && (nb == 32);
        case (sz)
            0:       begin fw = nb; mis = (off != 0);     end
            1:       begin fw = 8;  mis = 1'b0;           end
            2:       begin fw = 16; mis = (off % 2) != 0; end
            default: begin fw = 32; mis = (off % 4) != 0; end
        endcase
        defer = mis && !illegal;
        if (illegal) begin
            d = maskN(nb);
            e = 1'b1;
        end else if (mis && !merged) begin
            d = 64'd0;
            e = 1'b1;
        end else begin
            d = lane[63:0] & maskN(fw);
            if (!c && lane[fw-1]) d = d | (maskN(nb) & ~maskN(fw));
            e = 1'b0;
        end
    endtask

    // Compare one instance against the model, then advance the model by one edge
    task automatic modelStep(input int k, input int nb, input logic oV, input logic oR,
                             input logic [63:0] oD, input logic oE, input logic oQ,
                             input logic [63:0] inData, input int inOff, input logic [63:0] inNext);
        string       tag;
        bit          expReady, drain, acc, defer, e;
        logic [63:0] d;
        tag      = (k == 0) ? "m32" : "m64";
        expReady = !mWait[k] && (!mHave[k] || readyIn);
        checkOutput({tag, " o_valid"}, 64'(oV), 64'(mHave[k]));
        checkOutput({tag, " o_ready"}, 64'(oR), 64'(expReady));
        checkOutput({tag, " o_req_next"}, 64'(oQ), 64'(mWait[k]));
        if (mHave[k]) begin
            checkOutput({tag, " o_dato"}, oD, mDato[k]);
            checkOutput({tag, " o_error"}, 64'(oE), 64'(mErr[k]));
        end
        drain = mHave[k] && readyIn;
        acc   = valid && expReady;
        if (reset) begin
            mHave[k] = 1'b0;
            mWait[k] = 1'b0;
        end else begin
            if (mWait[k]) begin
                if (nextValid) begin
                    refLoad(nb, (128'(inNext) << nb) | 128'(sWord[k]), sOff[k], sSize[k],
                            sCero[k], 1'b1, d, e, defer);
                    mHave[k] = 1'b1;
                    mDato[k] = d;
                    mErr[k]  = e;
                    mWait[k] = 1'b0;
                end
            end else if (drain) begin
                mHave[k] = 1'b0;
            end
            if (acc) begin
                refLoad(nb, 128'(inData), inOff, int'(size), cero, 1'b0, d, e, defer);
                if (UNAL && defer) begin
                    mWait[k] = 1'b1;
                    mHave[k] = 1'b0;
                    sWord[k] = inData;
                    sOff[k]  = inOff;
                    sSize[k] = int'(size);
                    sCero[k] = cero;
                end else begin
                    mHave[k] = 1'b1;
                    mDato[k] = d;
                    mErr[k]  = e;
                end
            end
        end
    endtask

    // Compare process: samples just before each rising edge
    always @(negedge clk) begin
        #4;
        if (modelOn) begin
            modelStep(0, 32, valid32, ready32, 64'(dato32), err32, req32,
                      {32'h0, data[31:0]}, int'(offset[1:0]), {32'h0, nextData[31:0]});
            modelStep(1, 64, valid64, ready64, dato64, err64, req64,
                      data, int'(offset), nextData);
        end
    end

    // Called on a falling edge; one-cycle request, returns when the result is visible
    task automatic applyStimulus(input logic [63:0] d, input logic [2:0] off,
                                 input logic [1:0] sz, input bit c);
        data   = d;
        offset = off;
        size   = sz;
        cero   = c;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        valid     = 1'b0;
        readyIn   = 1'b1;
        cero      = 1'b0;
        nextValid = 1'b0;
        data      = 64'd0;
        nextData  = 64'd0;
        offset    = 3'd0;
        size      = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        modelOn = 1'b1;
        checkOutput("reset valid32", 64'(valid32), 64'd0);
        checkOutput("reset ready32", 64'(ready32), 64'd1);
        checkOutput("reset error32", 64'(err32), 64'd0);
        checkOutput("reset dato32", 64'(dato32), 64'd0);

        $display("[TB] byte loads, sign and zero");
        applyStimulus(64'h0000_0000_8765_43A1, 3'd0, 2'b01, 1'b0);
        checkOutput("t1 valid32", 64'(valid32), 64'd1);
        checkOutput("t1 dato32", 64'(dato32), 64'h0000_0000_FFFF_FFA1);
        checkOutput("t1 err32", 64'(err32), 64'd0);
        checkOutput("t1 dato64", dato64, 64'hFFFF_FFFF_FFFF_FFA1);
        applyStimulus(64'h0000_0000_8765_43A1, 3'd0, 2'b01, 1'b1);
        checkOutput("t1 dato32 zext", 64'(dato32), 64'h0000_0000_0000_00A1);

        $display("[TB] halfword loads");
        applyStimulus(64'h0000_0000_8765_43A1, 3'd2, 2'b10, 1'b0);
        checkOutput("t2 dato32", 64'(dato32), 64'h0000_0000_FFFF_8765);
        checkOutput("t2 err32", 64'(err32), 64'd0);
`ifndef FILTRO_LOAD_UNALIGNED_EN
        applyStimulus(64'h0000_0000_8765_43A1, 3'd1, 2'b10, 1'b0);
        checkOutput("t2 misal err32", 64'(err32), 64'd1);
        checkOutput("t2 misal dato32", 64'(dato32), 64'd0);
        checkOutput("t2 misal err64", 64'(err64), 64'd1);
`endif

        $display("[TB] word size on both widths");
        applyStimulus(64'h8000_0001_0000_0002, 3'd4, 2'b11, 1'b0);
        checkOutput("t3 err32", 64'(err32), 64'd1);
        checkOutput("t3 dato32", 64'(dato32), 64'h0000_0000_FFFF_FFFF);
        checkOutput("t3 err64", 64'(err64), 64'd0);
        checkOutput("t3 dato64", dato64, 64'hFFFF_FFFF_8000_0001);
        @(negedge clk);
        checkOutput("t3 drained valid32", 64'(valid32), 64'd0);

        $display("[TB] backpressure");
        readyIn = 1'b0;
        applyStimulus(64'h0000_0000_1234_5678, 3'd0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4 hold valid32", 64'(valid32), 64'd1);
            checkOutput("t4 hold ready32", 64'(ready32), 64'd0);
            checkOutput("t4 hold dato32", 64'(dato32), 64'h0000_0000_1234_5678);
            @(negedge clk);
        end
        readyIn = 1'b1;
        applyStimulus(64'h0000_0000_CAFE_00F0, 3'd2, 2'b01, 1'b0);
        checkOutput("t4 reload valid32", 64'(valid32), 64'd1);
        checkOutput("t4 reload dato32", 64'(dato32), 64'h0000_0000_FFFF_FFFE);
        @(negedge clk);

        $display("[TB] reset while full");
        readyIn = 1'b0;
        applyStimulus(64'h0000_0000_8765_43A1, 3'd0, 2'b11, 1'b0);
        checkOutput("t6 pre err32", 64'(err32), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t6 valid32", 64'(valid32), 64'd0);
        checkOutput("t6 err32", 64'(err32), 64'd0);
        checkOutput("t6 req32", 64'(req32), 64'd0);
        checkOutput("t6 ready32", 64'(ready32), 64'd1);
        readyIn = 1'b1;

`ifdef FILTRO_LOAD_UNALIGNED_EN
        $display("[TB] unaligned merge");
        applyStimulus(64'h0000_0000_4433_2211, 3'd3, 2'b10, 1'b1);
        checkOutput("t5 req32", 64'(req32), 64'd1);
        checkOutput("t5 wait valid32", 64'(valid32), 64'd0);
        checkOutput("t5 wait ready32", 64'(ready32), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t5 req32 held", 64'(req32), 64'd1);
        end
        nextData  = 64'h0000_0000_8877_6655;
        nextValid = 1'b1;
        @(negedge clk);
        nextValid = 1'b0;
        checkOutput("t5 valid32", 64'(valid32), 64'd1);
        checkOutput("t5 dato32", 64'(dato32), 64'h0000_0000_0000_5544);
        checkOutput("t5 err32", 64'(err32), 64'd0);
        checkOutput("t5 req32 done", 64'(req32), 64'd0);

        $display("[TB] reset while waiting");
        applyStimulus(64'h0000_0000_4433_2211, 3'd3, 2'b10, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t6w req32", 64'(req32), 64'd0);
        checkOutput("t6w valid32", 64'(valid32), 64'd0);
        checkOutput("t6w ready32", 64'(ready32), 64'd1);
`endif

        $display("[TB] vector table");
        nextData  = 64'h0123_4567_89AB_CDEF;
        nextValid = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].d, vecs[i].off, vecs[i].sz, vecs[i].c);
            @(negedge clk);
        end
        nextValid = 1'b0;
        repeat (2) @(negedge clk);
        #6;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
